// File: rtl/fp_pkg.sv
// Shared float-format definitions for the integer converter and the FP adder:
// default field widths, converter state encoding and the special encodings.
package fp_pkg;
  localparam int FP_EXP_W  = 4;
  localparam int FP_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  localparam fp_t FP_ZERO = '{sign: 1'b0, exp: '0, frac: '0};
  // Most-negative input saturates to the largest negative magnitude.
  localparam fp_t FP_SAT  = '{sign: 1'b1, exp: '1, frac: '1};
endpackage

// File: rtl/int_to_fp_converter_if.sv
// Handshake bundle for the converter: integer in, float fields out.
interface int_to_fp_converter_if #(
  parameter int IN_W   = 16,
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] frac_out;
  logic              inexact;
  logic              sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, frac_out, inexact, sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sign_out, exp_out, frac_out, inexact, sat
  );
endinterface

// File: rtl/int_to_fp_converter.sv
// Iterative signed-integer to sign/exp/frac converter: one left shift per cycle
// until the magnitude MSB reaches the top, then the fraction is truncated out.
module int_to_fp_converter
  import fp_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  int_to_fp_converter_if.slave  bus
);
  localparam int M = IN_W - 1;
  localparam logic [EXP_W-1:0] E_INIT = EXP_W'(M);

  state_t              state_q, state_d;
  logic [M-1:0]        sh_q, sh_d;
  logic [EXP_W-1:0]    e_q, e_d;
  logic                neg_q, neg_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                inexact_q, inexact_d;
  logic                sat_q, sat_d;

  logic                in_neg, in_zero, in_min, low_nz;
  logic [IN_W-1:0]     in_negated;
  logic [M-1:0]        in_mag;

  assign in_neg     = bus.in_data[IN_W-1];
  assign in_zero    = (bus.in_data == '0);
  assign in_min     = (bus.in_data == {1'b1, {M{1'b0}}});
  assign in_negated = -bus.in_data;
  // The most-negative value is intercepted by in_min, so M bits always suffice.
  assign in_mag     = in_neg ? in_negated[M-1:0] : bus.in_data[M-1:0];

  generate
    if (M > FRAC_W) begin : g_sticky
      assign low_nz = |sh_q[M-FRAC_W-1:0];
    end else begin : g_exact
      assign low_nz = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (in_zero || in_min) ? DONE : NORM;
      NORM:    if (sh_q[M-1])    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.sign_out  = sign_q;
    bus.exp_out   = exp_q;
    bus.frac_out  = frac_q;
    bus.inexact   = inexact_q;
    bus.sat       = sat_q;
  end

  always_comb begin
    sh_d      = sh_q;
    e_d       = e_q;
    neg_d     = neg_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    inexact_d = inexact_q;
    sat_d     = sat_q;
    if (state_q == IDLE && bus.in_valid) begin
      sh_d      = in_mag;
      e_d       = E_INIT;
      neg_d     = in_neg;
      inexact_d = 1'b0;
      sat_d     = 1'b0;
      if (in_zero) begin
        sign_d = 1'b0;
        exp_d  = '0;
        frac_d = '0;
      end else if (in_min) begin
        sign_d    = 1'b1;
        exp_d     = '1;
        frac_d    = '1;
        sat_d     = 1'b1;
        inexact_d = 1'b1;
      end
    end else if (state_q == NORM) begin
      if (!sh_q[M-1]) begin
        sh_d = sh_q << 1;
        e_d  = e_q - EXP_W'(1);
      end else begin
        sign_d    = neg_q;
        exp_d     = e_q;
        frac_d    = sh_q[M-1 -: FRAC_W];
        inexact_d = low_nz;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q      <= '0;
      e_q       <= '0;
      neg_q     <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      inexact_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      e_q       <= e_d;
      neg_q     <= neg_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      inexact_q <= inexact_d;
      sat_q     <= sat_d;
    end
  end
endmodule

// File: tb/tb_int_to_fp_converter.sv
// Vector table, randomized model comparison and handshake/reset corner cases.
module tb_int_to_fp_converter;
  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  int_to_fp_converter_if #(.IN_W(16), .EXP_W(4), .FRAC_W(8)) bus ();

  int_to_fp_converter #(.IN_W(16), .EXP_W(4), .FRAC_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          lat;
    logic        s;
    logic [3:0]  e;
    logic [7:0]  f;
    logic        ix;
    logic        st;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: value = 0.frac * 2^exp, truncated; latency 16-p edges for MSB at p.
  function automatic vec_t model(input logic [15:0] d);
    vec_t r;
    int v, mag, p, scaled, den;
    v = int'($signed(d));
    r.d = d;
    r.s = 1'b0; r.e = 4'd0; r.f = 8'd0; r.ix = 1'b0; r.st = 1'b0; r.lat = 1;
    if (v == -32768) begin
      r.s = 1'b1; r.e = 4'd15; r.f = 8'hFF; r.ix = 1'b1; r.st = 1'b1;
    end else if (v != 0) begin
      mag = (v < 0) ? -v : v;
      p = 0;
      while ((2 ** (p + 1)) <= mag) p++;
      den    = 2 ** (p + 1);
      scaled = mag * 256;
      r.s   = (v < 0);
      r.e   = 4'(p + 1);
      r.f   = 8'(scaled / den);
      r.ix  = (scaled % den) != 0;
      r.lat = 16 - p;
    end
    return r;
  endfunction

  // Called at a negedge just after the accepting edge; returns edges to out_valid.
  task automatic wait_result(input string nm, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      tests++; fails++;
      $display("FAIL %s timeout: out_valid never rose", nm);
    end
  endtask

  task automatic check_result(input string nm, input vec_t ex, input int lat);
    chk({nm, " latency"}, 32'(lat), 32'(ex.lat));
    chk({nm, " sign"},    32'(bus.sign_out), 32'(ex.s));
    chk({nm, " exp"},     32'(bus.exp_out),  32'(ex.e));
    chk({nm, " frac"},    32'(bus.frac_out), 32'(ex.f));
    chk({nm, " inexact"}, 32'(bus.inexact),  32'(ex.ix));
    chk({nm, " sat"},     32'(bus.sat),      32'(ex.st));
  endtask

  task automatic convert(input string nm, input vec_t ex);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = ex.d;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hDEAD;
    wait_result(nm, lat);
    check_result(nm, ex, lat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, " post out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t ex;
    int   lat;
    vecs[0] = '{16'h0001,  16, 1'b0, 4'd1,  8'h80, 1'b0, 1'b0};
    vecs[1] = '{16'h012D,   8, 1'b0, 4'd9,  8'h96, 1'b1, 1'b0};
    vecs[2] = '{16'h012C,   8, 1'b0, 4'd9,  8'h96, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFB,  14, 1'b1, 4'd3,  8'hA0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000,   1, 1'b1, 4'd15, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{16'h7FFF,   2, 1'b0, 4'd15, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000,   1, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0};

    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset fields", {bus.sign_out, bus.exp_out, bus.frac_out, bus.inexact, bus.sat}, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      convert($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] d;
      case (i % 3)
        0:       d = 16'($urandom);
        1:       d = 16'($urandom_range(0, 511)) ^ ({16{1'($urandom)}});
        default: d = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      convert($sformatf("rnd%0d(%h)", i, d), model(d));
    end

    // Backpressure: zero result held, a competing input is ignored until IDLE.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    @(negedge clk);
    bus.in_data  = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", c),  32'(bus.in_ready),  32'd0);
      chk($sformatf("hold%0d exp/frac", c),  {20'd0, bus.exp_out, bus.frac_out}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp accepted in_ready", 32'(bus.in_ready), 32'd0);
    wait_result("bp 1234", lat);
    check_result("bp 1234", model(16'h1234), lat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of normalisation aborts without a result.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midnorm in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    ex = '{16'h4000, 2, 1'b0, 4'd15, 8'h80, 1'b0, 1'b0};
    convert("after abort", ex);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
